// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// video_timing_gen
//    Programmable raster timing generator. Free-running H/V counters produce
//    registered sync, data-enable, early read strobe and frame-start outputs.
//    All timing inputs are captured into a shadow set when RUN is entered and
//    at every frame wrap, so mid-frame input changes apply to the next frame.
//
// Parameters
//    pCNT_W     width of the timing inputs and of the H/V counters
//    pRD_LEAD   cycles by which o_rd leads o_de (0..15)
//    pSYNC_POL  active level of o_hsyn/o_vsyn (1 = active-high)
//
// Ports
//    i_video_clk          pixel clock, rising edge
//    i_rst_n              asynchronous active-low reset
//    i_enable             generator enable (level)
//    i_hs_total_num       pixels per line
//    i_vs_total_num       lines per frame
//    i_hsyn_num           hsync width in pixels
//    i_vsyn_num           vsync width in lines
//    i_video_start_pixel  active window H start (inclusive)
//    i_video_end_pixel    active window H end (exclusive)
//    i_video_start_H      active window V start (inclusive)
//    i_video_end_H        active window V end (exclusive)
//    i_ext_vsyn           external frame reference, active-high
//    o_hsyn / o_vsyn      sync outputs
//    o_de                 data enable
//    o_rd                 read strobe, o_de shifted pRD_LEAD cycles earlier
//    o_frame_start        one-cycle pulse on the h=0, v=0 output cycle
//    o_locked             frame-lock status
//
// Build option
//    VIDEO_TIMING_GEN_LOCK_EN  when defined, a rising edge of i_ext_vsyn
//    realigns the raster to h=0, v=0 and o_locked reports two consecutive
//    references landing on the natural frame wrap. When undefined,
//    i_ext_vsyn is ignored and o_locked is held at 0.
// ----------------------------------------------------------------------------
module video_timing_gen #(
   parameter int unsigned pCNT_W    = 13,
   parameter int unsigned pRD_LEAD  = 2,
   parameter int unsigned pSYNC_POL = 1
) (
   input  logic              i_video_clk,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic [pCNT_W-1:0] i_hs_total_num,
   input  logic [pCNT_W-1:0] i_vs_total_num,
   input  logic [pCNT_W-1:0] i_hsyn_num,
   input  logic [pCNT_W-1:0] i_vsyn_num,
   input  logic [pCNT_W-1:0] i_video_start_pixel,
   input  logic [pCNT_W-1:0] i_video_end_pixel,
   input  logic [pCNT_W-1:0] i_video_start_H,
   input  logic [pCNT_W-1:0] i_video_end_H,
   input  logic              i_ext_vsyn,
   output logic              o_hsyn,
   output logic              o_vsyn,
   output logic              o_de,
   output logic              o_rd,
   output logic              o_frame_start,
   output logic              o_locked
);

   localparam logic SYNC_ON  = (pSYNC_POL != 0);
   localparam logic SYNC_OFF = !SYNC_ON;

   localparam logic [pCNT_W-1:0] CNT_ONE = pCNT_W'(1);
   localparam logic [pCNT_W-1:0] CNT_TWO = pCNT_W'(2);
   localparam logic [pCNT_W:0]   RD_LEAD = (pCNT_W+1)'(pRD_LEAD);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef struct packed {
      logic [pCNT_W-1:0] hs_total;
      logic [pCNT_W-1:0] vs_total;
      logic [pCNT_W-1:0] hsyn;
      logic [pCNT_W-1:0] vsyn;
      logic [pCNT_W-1:0] start_pixel;
      logic [pCNT_W-1:0] end_pixel;
      logic [pCNT_W-1:0] start_h;
      logic [pCNT_W-1:0] end_h;
   } timing_t;

   state_t            state;
   timing_t           live;
   timing_t           shadow;
   logic [pCNT_W-1:0] h_cnt;
   logic [pCNT_W-1:0] v_cnt;

   logic              live_valid;
   logic              h_last;
   logic              v_last;
   logic              frame_wrap;
   logic              restart;
   logic [pCNT_W:0]   h_lead;
   logic              hsyn_act;
   logic              vsyn_act;
   logic              de_h;
   logic              rd_h;
   logic              win_v;
   logic              de_act;
   logic              rd_act;
   logic              fs_act;

`ifdef VIDEO_TIMING_GEN_LOCK_EN
   logic              ext_d;
   logic              ext_rise;
   logic              lock_seen;
   logic              locked;
`endif

   // ------------------------------------------------------------------------
   // Decode of the current counter position against the shadow timing
   // ------------------------------------------------------------------------
   always_comb begin
      live             = '0;
      live.hs_total    = i_hs_total_num;
      live.vs_total    = i_vs_total_num;
      live.hsyn        = i_hsyn_num;
      live.vsyn        = i_vsyn_num;
      live.start_pixel = i_video_start_pixel;
      live.end_pixel   = i_video_end_pixel;
      live.start_h     = i_video_start_H;
      live.end_h       = i_video_end_H;

      live_valid = (i_hs_total_num >= CNT_TWO) && (i_vs_total_num >= CNT_TWO);

      h_last     = (h_cnt == shadow.hs_total - CNT_ONE);
      v_last     = (v_cnt == shadow.vs_total - CNT_ONE);
      frame_wrap = h_last && v_last;

      hsyn_act = (h_cnt < shadow.hsyn);
      vsyn_act = (v_cnt < shadow.vsyn);

      // Half-open windows: an empty or inverted window never matches.
      win_v = (v_cnt >= shadow.start_h) && (v_cnt < shadow.end_h);
      de_h  = (h_cnt >= shadow.start_pixel) && (h_cnt < shadow.end_pixel);

      // Lead position is one bit wider so it never folds into the next line;
      // a start below the lead simply clips the strobe at h=0.
      h_lead = {1'b0, h_cnt} + RD_LEAD;
      rd_h   = (h_lead >= {1'b0, shadow.start_pixel}) &&
               (h_lead <  {1'b0, shadow.end_pixel});

      de_act = de_h && win_v;
      rd_act = rd_h && win_v;
      fs_act = (h_cnt == '0) && (v_cnt == '0);

`ifdef VIDEO_TIMING_GEN_LOCK_EN
      ext_rise = i_ext_vsyn && !ext_d;
      restart  = frame_wrap || ext_rise;
`else
      restart  = frame_wrap;
`endif
   end

   // ------------------------------------------------------------------------
   // State, counters, shadow timing and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge i_video_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state         <= IDLE;
         h_cnt         <= '0;
         v_cnt         <= '0;
         shadow        <= '0;
         o_hsyn        <= SYNC_OFF;
         o_vsyn        <= SYNC_OFF;
         o_de          <= 1'b0;
         o_rd          <= 1'b0;
         o_frame_start <= 1'b0;
`ifdef VIDEO_TIMING_GEN_LOCK_EN
         ext_d         <= 1'b0;
         lock_seen     <= 1'b0;
         locked        <= 1'b0;
`endif
      end else begin
         o_hsyn        <= SYNC_OFF;
         o_vsyn        <= SYNC_OFF;
         o_de          <= 1'b0;
         o_rd          <= 1'b0;
         o_frame_start <= 1'b0;
`ifdef VIDEO_TIMING_GEN_LOCK_EN
         ext_d         <= i_ext_vsyn;
`endif

         case (state)
            IDLE: begin
               h_cnt <= '0;
               v_cnt <= '0;
               if (i_enable && live_valid) begin
                  state  <= RUN;
                  shadow <= live;
               end
            end

            RUN: begin
               if (!i_enable) begin
                  state <= IDLE;
                  h_cnt <= '0;
                  v_cnt <= '0;
`ifdef VIDEO_TIMING_GEN_LOCK_EN
                  lock_seen <= 1'b0;
                  locked    <= 1'b0;
`endif
               end else begin
                  o_hsyn        <= hsyn_act ? SYNC_ON : SYNC_OFF;
                  o_vsyn        <= vsyn_act ? SYNC_ON : SYNC_OFF;
                  o_de          <= de_act;
                  o_rd          <= rd_act;
                  o_frame_start <= fs_act;

                  if (restart) begin
                     h_cnt <= '0;
                     v_cnt <= '0;
                     // A degenerate new set is refused; the running timing
                     // is kept rather than stalling the raster.
                     if (live_valid) begin
                        shadow <= live;
                     end
                  end else if (h_last) begin
                     h_cnt <= '0;
                     v_cnt <= v_cnt + CNT_ONE;
                  end else begin
                     h_cnt <= h_cnt + CNT_ONE;
                  end

`ifdef VIDEO_TIMING_GEN_LOCK_EN
                  if (ext_rise) begin
                     if (frame_wrap) begin
                        lock_seen <= 1'b1;
                        if (lock_seen) begin
                           locked <= 1'b1;
                        end
                     end else begin
                        lock_seen <= 1'b0;
                        locked    <= 1'b0;
                     end
                  end
`endif
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef VIDEO_TIMING_GEN_LOCK_EN
   assign o_locked = locked;
`else
   logic ext_unused;
   assign ext_unused = i_ext_vsyn;
   assign o_locked   = 1'b0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_video_timing_gen
//    Directed bench for video_timing_gen with default parameters. Uses a
//    1080p line (2200 px, window 192..2112, hsync 44) over a short 4-line
//    frame, plus small rasters for window corner cases. Outputs are sampled
//    on the falling clock edge; "index" below is the output cycle counted
//    from the o_frame_start sample (index k reflects linear position k).
// ----------------------------------------------------------------------------
module tb_video_timing_gen;

   localparam int W     = 13;
   localparam int BOUND = 20000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         enable = 1'b0;
   logic [W-1:0] hs_total, vs_total, hsyn_num, vsyn_num;
   logic [W-1:0] start_pixel, end_pixel, start_h, end_h;
   logic         ext_vsyn = 1'b0;
   logic         hsyn, vsyn, de, rd, frame_start, locked;

   int checks   = 0;
   int failures = 0;

   video_timing_gen #(
      .pCNT_W   (W),
      .pRD_LEAD (2),
      .pSYNC_POL(1)
   ) dut (
      .i_video_clk        (clk),
      .i_rst_n            (rst_n),
      .i_enable           (enable),
      .i_hs_total_num     (hs_total),
      .i_vs_total_num     (vs_total),
      .i_hsyn_num         (hsyn_num),
      .i_vsyn_num         (vsyn_num),
      .i_video_start_pixel(start_pixel),
      .i_video_end_pixel  (end_pixel),
      .i_video_start_H    (start_h),
      .i_video_end_H      (end_h),
      .i_ext_vsyn         (ext_vsyn),
      .o_hsyn             (hsyn),
      .o_vsyn             (vsyn),
      .o_de               (de),
      .o_rd               (rd),
      .o_frame_start      (frame_start),
      .o_locked           (locked)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_timing(input int hs, input int vs, input int hw, input int vw,
                             input int sp, input int ep, input int sv, input int ev);
      hs_total    = W'(hs);
      vs_total    = W'(vs);
      hsyn_num    = W'(hw);
      vsyn_num    = W'(vw);
      start_pixel = W'(sp);
      end_pixel   = W'(ep);
      start_h     = W'(sv);
      end_h       = W'(ev);
   endtask

   // Count falling edges until o_frame_start is seen (0 if already high).
   task automatic wait_fs(output int n);
      n = 0;
      while (!frame_start && n < BOUND) begin
         @(negedge clk);
         n++;
      end
   endtask

   // Called on the frame-start sample; returns on the next one.
   task automatic measure_frame(output int period, output int de_n, output int rd_n,
                                output int hs_n, output int vs_n,
                                output int first_de, output int first_rd);
      int i;
      i = 0; de_n = 0; rd_n = 0; hs_n = 0; vs_n = 0;
      first_de = -1; first_rd = -1;
      do begin
         if (de) begin
            de_n++;
            if (first_de < 0) first_de = i;
         end
         if (rd) begin
            rd_n++;
            if (first_rd < 0) first_rd = i;
         end
         if (hsyn) hs_n++;
         if (vsyn) vs_n++;
         @(negedge clk);
         i++;
      end while (!frame_start && i < BOUND);
      period = i;
   endtask

   // From IDLE: enter RUN on the next edge, frame start one cycle later.
   task automatic enable_run(input string tag);
      enable = 1'b1;
      @(negedge clk);
      check({tag, "_fs_early"}, frame_start, 0);
      @(negedge clk);
      check({tag, "_fs"}, frame_start, 1);
   endtask

   initial begin
      int period, de_n, rd_n, hs_n, vs_n, first_de, first_rd, n, cnt;

      set_timing(2200, 4, 44, 1, 192, 2112, 1, 3);

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_hsyn",   hsyn, 0);
      check("rst_vsyn",   vsyn, 0);
      check("rst_de",     de, 0);
      check("rst_rd",     rd, 0);
      check("rst_fs",     frame_start, 0);
      check("rst_locked", locked, 0);

      // Idle after release keeps outputs inactive
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_hsyn", hsyn, 0);
      check("idle_fs",   frame_start, 0);

      // 1080p line over a 4-line frame
      enable_run("start");
      measure_frame(period, de_n, rd_n, hs_n, vs_n, first_de, first_rd);
      check("a_period",   period, 8800);
      check("a_de",       de_n, 3840);
      check("a_rd",       rd_n, 3840);
      check("a_hsyn",     hs_n, 176);
      check("a_vsyn",     vs_n, 2200);
      check("a_first_de", first_de, 2392);
      check("a_first_rd", first_rd, 2390);

      // Mid-frame line length change applies from the next frame
      repeat (1000) @(negedge clk);
      hs_total = W'(1650);
      wait_fs(n);
      check("chg_rest", n, 7800);
      measure_frame(period, de_n, rd_n, hs_n, vs_n, first_de, first_rd);
      check("chg_period", period, 6600);
      check("chg_de",     de_n, 2916);
      check("chg_hsyn",   hs_n, 176);

      // Enable drop inside the active window
      repeat (3799) @(negedge clk);
      check("dis_de_before", de, 1);
      check("dis_rd_before", rd, 1);
      enable = 1'b0;
      @(negedge clk);
      check("dis_de", de, 0);
      check("dis_rd", rd, 0);
      check("dis_fs", frame_start, 0);
      repeat (3) @(negedge clk);
      check("dis_de_idle", de, 0);
      enable_run("reen");

      // Asynchronous reset inside the active window
      repeat (3799) @(negedge clk);
      check("arst_de_before", de, 1);
      rst_n = 1'b0;
      #1;
      check("arst_de", de, 0);
      check("arst_rd", rd, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_fs(n);
      check("arst_fs_lat", n, 2);
      measure_frame(period, de_n, rd_n, hs_n, vs_n, first_de, first_rd);
      check("arst_period",   period, 6600);
      check("arst_first_de", first_de, 1842);
      check("arst_first_rd", first_rd, 1840);

      // Empty H window: end == start
      enable = 1'b0;
      @(negedge clk);
      set_timing(20, 6, 3, 2, 10, 10, 1, 5);
      enable_run("small");
      measure_frame(period, de_n, rd_n, hs_n, vs_n, first_de, first_rd);
      check("b_period", period, 120);
      check("b_de",     de_n, 0);
      check("b_rd",     rd_n, 0);
      check("b_hsyn",   hs_n, 18);
      check("b_vsyn",   vs_n, 40);

      // Start below the read lead: rd clipped at h=0
      set_timing(20, 6, 3, 2, 1, 8, 1, 5);
      measure_frame(period, de_n, rd_n, hs_n, vs_n, first_de, first_rd);
      measure_frame(period, de_n, rd_n, hs_n, vs_n, first_de, first_rd);
      check("c_period",   period, 120);
      check("c_de",       de_n, 28);
      check("c_rd",       rd_n, 24);
      check("c_first_de", first_de, 21);
      check("c_first_rd", first_rd, 20);

      // Degenerate line length is refused while enabled
      enable = 1'b0;
      @(negedge clk);
      hs_total = W'(1);
      enable   = 1'b1;
      cnt = 0;
      repeat (20) begin
         @(negedge clk);
         cnt += int'(frame_start) + int'(de) + int'(hsyn);
      end
      check("invalid_idle", cnt, 0);
      hs_total = W'(20);
      wait_fs(n);
      check("valid_start", n, 2);

      // External reference
`ifdef VIDEO_TIMING_GEN_LOCK_EN
      repeat (50) @(negedge clk);
      ext_vsyn = 1'b1;
      @(negedge clk);
      ext_vsyn = 1'b0;
      wait_fs(n);
      check("realign_lat",    n, 1);
      check("realign_locked", locked, 0);
      for (int k = 0; k < 2; k++) begin
         repeat (118) @(negedge clk);
         ext_vsyn = 1'b1;
         @(negedge clk);
         ext_vsyn = 1'b0;
         check($sformatf("aligned%0d_locked", k), locked, (k == 1) ? 1 : 0);
         @(negedge clk);
         check($sformatf("aligned%0d_fs", k), frame_start, 1);
      end
      enable = 1'b0;
      @(negedge clk);
      check("idle_unlock", locked, 0);
`else
      repeat (50) @(negedge clk);
      ext_vsyn = 1'b1;
      @(negedge clk);
      ext_vsyn = 1'b0;
      check("ext_locked", locked, 0);
      wait_fs(n);
      check("ext_ignored", n, 69);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter pCNT_W, default 13: width of all timing inputs and the internal H/V counters.
REQ-002 Parameter pRD_LEAD, default 2: number of cycles by which o_rd leads o_de (range 0..15).
REQ-003 Parameter pSYNC_POL, default 1: active level of o_hsyn/o_vsyn (1 = active-high).
REQ-004 i_video_clk  in  1  single clock; all logic is clocked on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_enable  in  1  frame generator enable (level).
REQ-007 i_hs_total_num / i_vs_total_num  in  pCNT_W  pixels per line / lines per frame.
REQ-008 i_hsyn_num / i_vsyn_num  in  pCNT_W  sync pulse width in pixels / lines.
REQ-009 i_video_start_pixel / i_video_end_pixel  in  pCNT_W  active window in H, half-open [start,end).
REQ-010 i_video_start_H / i_video_end_H  in  pCNT_W  active window in V, half-open [start,end).
REQ-011 i_ext_vsyn  in  1  external frame reference, same clock domain, active-high.
REQ-012 o_hsyn, o_vsyn, o_de, o_rd  out  1  registered timing outputs.
REQ-013 o_frame_start  out  1  one-cycle pulse on the output cycle of h=0, v=0.
REQ-014 o_locked  out  1  frame-lock status.

Function
REQ-015 The block SHALL implement states IDLE and RUN, with h_cnt (0..hs_total-1) and v_cnt (0..vs_total-1).
REQ-016 IDLE->RUN SHALL occur when i_enable=1 and the inputs are valid (hs_total>=2, vs_total>=2); RUN->IDLE SHALL occur when i_enable=0, taking effect within 1 cycle.
REQ-017 In IDLE the counters SHALL be held at 0 and all outputs SHALL be inactive.
REQ-018 In RUN, h_cnt SHALL increment every cycle and wrap to 0 at hs_total-1; v_cnt SHALL increment on each h wrap and wrap to 0 at vs_total-1.
REQ-019 All timing inputs SHALL be sampled into shadow registers on entry to RUN and at each v wrap (h=hs_total-1, v=vs_total-1) only; mid-frame input changes SHALL have no effect until the next frame.
REQ-020 hsyn active = h_cnt<hsyn_num; vsyn active = v_cnt<vsyn_num.
REQ-021 de = (start_pixel<=h_cnt<end_pixel) AND (start_H<=v_cnt<end_H). If end<=start on either axis, de SHALL never assert.
REQ-022 rd SHALL use the de equation with h_cnt+pRD_LEAD substituted for h_cnt, summed in pCNT_W+1 bits with no wrap into the next line. If start_pixel<pRD_LEAD, rd SHALL be truncated at h=0.
REQ-023 Every output SHALL be registered once: the output on cycle n+1 reflects the counter values of cycle n.
REQ-024 Sync polarity SHALL follow pSYNC_POL. The inactive level SHALL be used in IDLE and during reset.
REQ-025 The number of o_rd cycles per line SHALL equal the number of o_de cycles per line whenever start_pixel>=pRD_LEAD.

Reset
REQ-026 While i_rst_n=0: state=IDLE, counters=0, shadow registers=0, o_de=o_rd=o_frame_start=o_locked=0, o_hsyn/o_vsyn inactive.
REQ-027 Reset assertion SHALL take effect immediately, including mid-frame. After release, the first frame SHALL start from h=0, v=0.

Configuration
REQ-028 Macro VIDEO_TIMING_GEN_LOCK_EN SHALL compile the frame-lock feature in or out.
REQ-029 With the macro defined, a rising edge of i_ext_vsyn in RUN SHALL force h_cnt=0, v_cnt=0 on the next cycle and reload the shadow registers.
REQ-030 With the macro defined, o_locked SHALL go to 1 after 2 consecutive ext edges that coincide with the natural frame wrap.
REQ-031 With the macro defined, o_locked SHALL clear on any forced realignment or on a return to IDLE.
REQ-032 Without the macro, i_ext_vsyn SHALL be ignored and o_locked SHALL be tied to 0.

Verification
REQ-033 1080p60 (hs_total 2200, vs_total 1125, hsyn 44, vsyn 5, start/end pixel 192/2112, start/end H 41/1121): expect o_de count per frame = 2073600, frame period 2475000 cycles, o_hsyn width 44, o_vsyn width 5 lines.
REQ-034 pRD_LEAD=2, same timing: expect the first o_rd of a line 2 cycles before the first o_de, and 1920 o_rd cycles per active line.
REQ-035 Change hs_total to 1650 mid-frame: expect the current frame to complete at 2200 per line and the next frame at 1650.
REQ-036 Deassert i_enable at h=100, v=500: expect all outputs inactive 1 cycle later. Re-enable: expect o_frame_start 1 cycle after entering RUN.
REQ-037 LOCK_EN defined, pulse i_ext_vsyn at v=300: expect realignment to h=0, v=0, o_locked=0. Then pulses every 2475000 cycles aligned to the wrap: expect o_locked=1 after the 2nd aligned pulse.
REQ-038 Assert i_rst_n=0 mid-active line: expect o_de=0 in the same cycle, and a first frame starting from h=0, v=0 after release.
